// File: rtl/prog_loader.sv
// prog_loader: serialises a byte stream LSB-first onto the configuration chain, CHAIN_LEN bits per session.
// Optional trailing CRC-8 check byte enabled by PROG_LOADER_CRC_EN.
module prog_loader #(
    parameter int CHAIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       prog_en,
    output logic       prog_in,
    output logic       busy,
    output logic       done,
    output logic       crc_err
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [6:0] sr;
    logic [2:0] left, left_n;
    int rem;
    // bits still to shift after the first one of the incoming byte
    always_comb begin
        rem = CHAIN_LEN - int'(cnt);
        left_n = rem >= 8 ? 3'd7 : 3'(rem - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            left <= '0;
            data_ready <= 1'b0;
            prog_en <= 1'b0;
            prog_in <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= LOAD;
                    data_ready <= 1'b1;
                    busy <= 1'b1;
                    done <= 1'b0;
                    cnt <= '0;
                end
                LOAD: if (data_valid) begin
                    state <= SHIFT;
                    data_ready <= 1'b0;
                    prog_en <= 1'b1;
                    prog_in <= data_in[0];
                    sr <= data_in[7:1];
                    left <= left_n;
                    cnt <= cnt + CNT_W'(1);
                end
                SHIFT: if (left != 3'd0) begin
                    prog_in <= sr[0];
                    sr <= sr >> 1;
                    left <= left - 3'd1;
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    prog_en <= 1'b0;
                    if (cnt == CNT_W'(CHAIN_LEN)) begin
`ifdef PROG_LOADER_CRC_EN
                        state <= CHECK;
                        data_ready <= 1'b1;
`else
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
`endif
                    end else begin
                        state <= LOAD;
                        data_ready <= 1'b1;
                    end
                end
                CHECK: if (data_valid) begin
                    state <= DONE;
                    data_ready <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef PROG_LOADER_CRC_EN
    logic [7:0] crc;
    logic shift_now, bit_now;
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction
    // the CRC follows exactly the bits that reach the chain
    always_comb begin
        shift_now = (state == LOAD && data_valid) || (state == SHIFT && left != 3'd0);
        bit_now = state == LOAD ? data_in[0] : sr[0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
            crc_err <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            crc <= '0;
            crc_err <= 1'b0;
        end else if (shift_now) begin
            crc <= crc_step(crc, bit_now);
        end else if (state == CHECK && data_valid) begin
            crc_err <= data_in != crc;
        end
    end
`else
    assign crc_err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed checks of prog_loader against a queue-based bit model.
module tb_prog_loader;
    localparam int N = 12;
`ifdef PROG_LOADER_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, start, data_valid, data_ready, prog_en, prog_in, busy, done, crc_err;
    logic [7:0] data_in;
    logic start8, valid8, ready8, en8, in8, busy8, done8, err8;
    logic [7:0] data8;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    prog_loader #(.CHAIN_LEN(N)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .prog_en(prog_en), .prog_in(prog_in), .busy(busy),
        .done(done), .crc_err(crc_err)
    );
    prog_loader #(.CHAIN_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_in(data8), .data_valid(valid8),
        .data_ready(ready8), .prog_en(en8), .prog_in(in8), .busy(busy8),
        .done(done8), .crc_err(err8)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // model: mode 0 idle, 1 awaiting data byte, 2 shifting, 3 awaiting CRC byte, 4 done
    int mode = 0, m_cnt = 0;
    bit q[$];
    bit m_en = 0, m_in = 0, m_done = 0, m_err = 0, armed = 0;
    logic [7:0] m_crc = 8'h00;
    always @(posedge clk) begin
        if (rst) begin
            armed = 1;
            mode = 0; q.delete(); m_cnt = 0; m_en = 0; m_in = 0; m_done = 0; m_err = 0; m_crc = 0;
        end else begin
            m_en = 0;
            case (mode)
                0, 4: if (start) begin mode = 1; m_done = 0; m_err = 0; m_cnt = 0; m_crc = 0; end
                1: if (data_valid) begin
                    for (int k = 0; k < ((N - m_cnt) < 8 ? N - m_cnt : 8); k++) q.push_back(data_in[k]);
                    mode = 2;
                end
                2: if (q.size() == 0) begin
                    mode = m_cnt == N ? (CRC ? 3 : 4) : 1;
                    if (mode == 4) m_done = 1;
                end
                3: if (data_valid) begin m_err = data_in != m_crc; m_done = 1; mode = 4; end
                default: mode = 0;
            endcase
            if (mode == 2 && q.size() > 0) begin
                m_in = q.pop_front();
                m_en = 1;
                m_cnt++;
                m_crc = {m_crc[6:0], 1'b0} ^ ((m_crc[7] ^ m_in) ? 8'h07 : 8'h00);
            end
        end
    end

    bit seen[$];
    int cnt8 = 0, ones8 = 0;
    always @(negedge clk) begin
        if (armed) begin
            chk("data_ready", data_ready, mode == 1 || mode == 3);
            chk("prog_en", prog_en, m_en);
            chk("prog_in", prog_in, m_in);
            chk("busy", busy, mode >= 1 && mode <= 3);
            chk("done", done, m_done);
            chk("crc_err", crc_err, m_err);
        end
        if (prog_en === 1'b1) seen.push_back(prog_in);
        if (en8 === 1'b1) begin cnt8++; ones8 += int'(in8); end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_session();
        start = 1; tick(); start = 0; seen.delete();
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        data_in = b; data_valid = 1;
        for (int i = 0; i < 100; i++) begin
            acc = data_ready;
            tick();
            if (acc) begin data_valid = 0; return; end
        end
        data_valid = 0;
        chk("send_timeout", 1, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (done) return;
            tick();
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic send_crc();
        if (CRC) send(m_crc);
    endtask

    logic [11:0] exp_bits;
    logic acc8;
    initial begin
        rst = 1; start = 0; data_valid = 0; data_in = 0; start8 = 0; valid8 = 0; data8 = 0;
        repeat (2) tick();
        rst = 0; tick();
        chk("rst_ready", data_ready, 0); chk("rst_en", prog_en, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", crc_err, 0);
        data_valid = 1; data_in = 8'h5A; repeat (3) tick();
        chk("idle_ready", data_ready, 0); chk("idle_en", prog_en, 0); data_valid = 0;

        begin_session();
        for (int i = 0; i < 5; i++) begin
            tick(); chk("bp_ready", data_ready, 1); chk("bp_en", prog_en, 0);
        end
        send(8'hA5); send(8'h3C); send_crc(); wait_done();
        chk("a5_count", seen.size(), 12);
        exp_bits = 12'b1100_1010_0101;
        for (int i = 0; i < 12 && i < seen.size(); i++) chk("a5_bit", seen[i], exp_bits[i]);
        chk("a5_err", crc_err, 0);

        begin_session();
        chk("done_drop", done, 0);
        send(8'h81); tick(); start = 1; tick(); start = 0;
        send(8'h42); send_crc(); wait_done();
        chk("busy_start_count", seen.size(), 12);

        begin_session(); send(8'hFF); tick(); rst = 1; repeat (2) tick(); rst = 0;
        chk("mid_rst_en", prog_en, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
        data_valid = 1; repeat (3) tick(); data_valid = 0;
        chk("mid_rst_ready", data_ready, 0); chk("mid_rst_en2", prog_en, 0);

        if (CRC) begin
            begin_session(); send(8'h00); send(8'h00); send(8'h00); wait_done();
            chk("crc_ok_err", crc_err, 0); chk("crc_ok_done", done, 1); chk("crc_ok_count", seen.size(), 12);
            begin_session(); send(8'h00); send(8'h00); send(8'h01); wait_done();
            chk("crc_bad_err", crc_err, 1); chk("crc_bad_done", done, 1); chk("crc_bad_count", seen.size(), 12);
        end

        start8 = 1; tick(); start8 = 0; cnt8 = 0; ones8 = 0;
        for (int b = 0; b < (CRC ? 2 : 1); b++) begin
            data8 = 8'hFF; valid8 = 1;
            for (int i = 0; i < 50; i++) begin
                acc8 = ready8; tick();
                if (acc8) break;
            end
            valid8 = 0;
        end
        for (int i = 0; i < 20 && !done8; i++) tick();
        chk("len8_count", cnt8, 8); chk("len8_ones", ones8, 8); chk("len8_done", done8, 1);
        chk("len8_ready", ready8, 0);

        for (int i = 0; i < 3000; i++) begin
            start = $urandom_range(0, 24) == 0;
            data_valid = $urandom_range(0, 1) == 1;
            data_in = 8'($urandom);
            rst = $urandom_range(0, 399) == 0;
            tick();
        end
        rst = 0; start = 0; data_valid = 0; tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
